// File: rtl/signal_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, repeated rep_cnt_in times.
// Define SIGNAL_GEN_GAP_EN to insert one idle GAP cycle between consecutive repetitions.
module signal_gen #(
    parameter int PATTERN_W = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [CNT_W-1:0]     rep_cnt_in,
    input  logic                 abort,
    output logic                 signal_out,
    output logic                 en_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [1:0]           state_dbg
);

    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PATTERN_W - 1);
    localparam logic [IDX_W-1:0] IDX_NEXT = IDX_W'(PATTERN_W - 2);

`ifdef SIGNAL_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]       rep_q, rep_d;
    logic [IDX_W-1:0]       bit_q, bit_d;
    logic                   sig_q, sig_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    // Handshake: start is a level request with no ready; it is honoured only in IDLE with
    // rep_cnt_in != 0 and no abort, and pattern/count are captured on that edge only.
    // bit_q holds the index of the next bit to drive; IDX_TOP in SHIFT means bit 0 is on the line.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        bit_d     = bit_q;
        sig_d     = 1'b0;
        en_d      = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && start && (rep_cnt_in != '0)) begin
                    pat_d   = pattern_in;
                    rep_d   = rep_cnt_in;
                    sig_d   = pattern_in[PATTERN_W-1];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    bit_d   = IDX_NEXT;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bit_q == IDX_TOP) begin
                    if (rep_q > CNT_W'(1)) begin
                        rep_d  = rep_q - CNT_W'(1);
                        busy_d = 1'b1;
`ifdef SIGNAL_GEN_GAP_EN
                        state_d = GAP;
`else
                        sig_d = pat_q[PATTERN_W-1];
                        en_d  = 1'b1;
                        bit_d = IDX_NEXT;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    sig_d  = pat_q[bit_q];
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    bit_d  = (bit_q == '0) ? IDX_TOP : bit_q - IDX_W'(1);
                end
            end
`ifdef SIGNAL_GEN_GAP_EN
            GAP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    sig_d   = pat_q[PATTERN_W-1];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    bit_d   = IDX_NEXT;
                    state_d = SHIFT;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            bit_q     <= '0;
            sig_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            bit_q     <= bit_d;
            sig_q     <= sig_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign signal_out = sig_q;
    assign en_out     = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_signal_gen.sv
// Directed and random bench for signal_gen; expected output stream comes from a queue-based burst model.
module tb_signal_gen;

    localparam int W = 8;
    localparam int C = 4;
`ifdef SIGNAL_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] pattern_in;
    logic [C-1:0] rep_cnt_in;
    logic         abort;
    logic         signal_out, en_out, busy, done, aborted;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Output word layout: {signal_out, en_out, busy, done, aborted}
    logic [4:0] exp_q[$];
    logic [4:0] cur;

    signal_gen #(.PATTERN_W(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .rep_cnt_in(rep_cnt_in), .abort(abort), .signal_out(signal_out),
        .en_out(en_out), .busy(busy), .done(done), .aborted(aborted),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {signal_out, en_out, busy, done, aborted};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (sig,en,busy,done,abt) t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an accepted burst expands into its full output stream up front.
    task automatic model_step(input logic st, input logic [W-1:0] pat, input logic [C-1:0] rep,
                              input logic ab);
        if (cur[2]) begin
            if (ab) begin
                exp_q.delete();
                cur = 5'b00001;
            end else begin
                cur = exp_q.pop_front();
            end
        end else if (st && !ab && rep != 0) begin
            for (int r = 0; r < int'(rep); r++) begin
                for (int b = W - 1; b >= 0; b--) exp_q.push_back({pat[b], 4'b1100});
                if (GAP_EN && r < int'(rep) - 1) exp_q.push_back(5'b00100);
            end
            exp_q.push_back(5'b00010);
            cur = exp_q.pop_front();
        end else begin
            cur = 5'b00000;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input string tag, input logic st, input logic [W-1:0] pat,
                         input logic [C-1:0] rep, input logic ab);
        @(negedge clk);
        check(tag, outs(), cur);
        start      = st;
        pattern_in = pat;
        rep_cnt_in = rep;
        abort      = ab;
        model_step(st, pat, rep, ab);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, W'($urandom), C'($urandom), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; pattern_in = '0; rep_cnt_in = '0; abort = 1'b0;
        cur = 5'b00000;
        #1;
        check("reset_outputs", outs(), 5'b00000);
        repeat (2) @(negedge clk);
        check("reset_held", outs(), 5'b00000);
        rst_n = 1'b1;

        // Single repetition of A5, then settle.
        cycle("a5_start", 1'b1, 8'hA5, 4'd1, 1'b0);
        idle("a5_burst", 12);

        // Three repetitions of C3.
        cycle("c3_start", 1'b1, 8'hC3, 4'd3, 1'b0);
        idle("c3_burst", 30);

        // Zero repeat count is ignored.
        cycle("zero_rep", 1'b1, 8'hFF, 4'd0, 1'b0);
        cycle("zero_rep", 1'b1, 8'h81, 4'd0, 1'b0);
        idle("zero_rep_after", 3);

        // Start mid-burst with a different pattern is ignored.
        cycle("mid_start0", 1'b1, 8'h3C, 4'd2, 1'b0);
        idle("mid_start1", 4);
        cycle("mid_start2", 1'b1, 8'hFF, 4'd5, 1'b0);
        cycle("mid_start3", 1'b1, 8'h00, 4'd7, 1'b0);
        idle("mid_start4", 16);

        // Abort while bit 3 of repetition 2 is on the line.
        cycle("abort_mid_start", 1'b1, 8'h96, 4'd3, 1'b0);
        idle("abort_mid_run", GAP_EN ? 13 : 12);
        cycle("abort_mid", 1'b0, 8'h00, 4'd0, 1'b1);
        idle("abort_mid_after", 4);

        // Abort coincident with the final bit.
        cycle("abort_last_start", 1'b1, 8'h5A, 4'd1, 1'b0);
        idle("abort_last_run", 7);
        cycle("abort_last", 1'b0, 8'h00, 4'd0, 1'b1);
        idle("abort_last_after", 4);

        // Abort in IDLE, and abort together with start.
        cycle("abort_idle", 1'b0, 8'h00, 4'd0, 1'b1);
        cycle("abort_start", 1'b1, 8'hE7, 4'd2, 1'b1);
        idle("abort_start_after", 4);

        // Asynchronous reset between edges mid-burst.
        cycle("arst_start", 1'b1, 8'hB6, 4'd4, 1'b0);
        idle("arst_run", 10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_immediate", outs(), 5'b00000);
        start = 1'b0; abort = 1'b0;
        exp_q.delete();
        cur = 5'b00000;
        @(negedge clk);
        check("arst_held", outs(), 5'b00000);
        rst_n = 1'b1;

        // All-ones pattern, maximum repetitions.
        cycle("ff15_start", 1'b1, 8'hFF, 4'd15, 1'b0);
        idle("ff15_burst", 140);

        // Start held high: back-to-back single bursts.
        for (int i = 0; i < 30; i++) cycle("b2b", 1'b1, 8'h6D, 4'd1, 1'b0);
        idle("b2b_after", 12);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle("random", ($urandom_range(0, 3) == 0), W'($urandom), C'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0));
        idle("final", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
